// File: rtl/flag_event_sync_if.sv
// Handshake bundle between the event latch / consumer and flag_event_sync.
// slave is the sync block's view; master is the latch-and-consumer side.
interface flag_event_sync_if;
  logic       flag;
  logic       ack;
  logic       req;
  logic       clr;
  logic       busy;
  logic [7:0] evt_cnt;

  modport slave (
    input  flag,
    input  ack,
    output req,
    output clr,
    output busy,
    output evt_cnt
  );

  modport master (
    output flag,
    output ack,
    input  req,
    input  clr,
    input  busy,
    input  evt_cnt
  );
endinterface

// File: rtl/flag_event_sync.sv
// Synchronises an async event latch, qualifies it, hands it off on REQ/ACK,
// then pulses CLR to re-arm the latch.  States: IDLE wait | QUAL hold check |
// PEND req up | CLEAR clr pulse | WAITLOW wait for sync low.
module flag_event_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4,
  parameter int CLR_CYCLES  = 2
) (
  input  logic               i_c,
  input  logic               i_r,
  flag_event_sync_if.slave   bus
);

  localparam int CCW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] QCNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CCW-1:0]   CCNT_LOAD = CCW'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_QUAL    = 3'd1,
    S_PEND    = 3'd2,
    S_CLEAR   = 3'd3,
    S_WAITLOW = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic [CNT_W-1:0]       r_qcnt, w_qcnt_nxt;
  logic [CCW-1:0]         r_ccnt, w_ccnt_nxt;
  logic [7:0]             r_evt_cnt;
  logic                   w_evt_inc;
  logic                   r_req, r_clr, r_busy;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_c) begin
    if (i_r) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.flag};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_qcnt_nxt  = r_qcnt;
    w_ccnt_nxt  = r_ccnt;
    w_evt_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sync) begin
          if (HOLD_CYCLES == 1) begin
            w_state_nxt = S_PEND;
          end else begin
            w_state_nxt = S_QUAL;
            w_qcnt_nxt  = CNT_W'(1);
          end
        end
      end
      S_QUAL: begin
        if (!w_sync) begin
          w_state_nxt = S_IDLE;
          w_qcnt_nxt  = '0;
        end else if (r_qcnt == QCNT_LAST) begin
          w_state_nxt = S_PEND;
          w_qcnt_nxt  = '0;
        end else begin
          w_qcnt_nxt  = r_qcnt + CNT_W'(1);
        end
      end
      S_PEND: begin
        if (bus.ack) begin
          w_state_nxt = S_CLEAR;
          w_ccnt_nxt  = CCNT_LOAD;
          w_evt_inc   = 1'b1;
        end
      end
      S_CLEAR: begin
        // Down-counter: terminal count ends the CLR pulse.
        if (r_ccnt == '0) w_state_nxt = S_WAITLOW;
        else              w_ccnt_nxt  = r_ccnt - CCW'(1);
      end
      S_WAITLOW: begin
        if (!w_sync) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_qcnt_nxt  = '0;
        w_ccnt_nxt  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register glitch-free.
  always_ff @(posedge i_c) begin
    if (i_r) begin
      r_state   <= S_IDLE;
      r_qcnt    <= '0;
      r_ccnt    <= '0;
      r_evt_cnt <= '0;
      r_req     <= 1'b0;
      r_clr     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_qcnt  <= w_qcnt_nxt;
      r_ccnt  <= w_ccnt_nxt;
      r_req   <= (w_state_nxt == S_PEND);
      r_clr   <= (w_state_nxt == S_CLEAR);
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_evt_inc) r_evt_cnt <= r_evt_cnt + 8'd1;
    end
  end

  assign bus.req     = r_req;
  assign bus.clr     = r_clr;
  assign bus.busy    = r_busy;
  assign bus.evt_cnt = r_evt_cnt;

endmodule

// File: tb/tb_flag_event_sync.sv
// Directed bench for flag_event_sync with a behavioural event latch
// (CLR over PRE) driving FLAG; default parameters throughout.
module tb_flag_event_sync;

  logic i_c = 1'b0;
  logic i_r = 1'b1;
  logic pre = 1'b0;
  logic tb_clr = 1'b0;
  logic stuck = 1'b0;
  logic latch_q = 1'b0;
  int   checks = 0;
  int   errors = 0;

  flag_event_sync_if bus ();

  flag_event_sync u_dut (
    .i_c (i_c),
    .i_r (i_r),
    .bus (bus.slave)
  );

  always #5 i_c = ~i_c;

  always @(bus.clr or pre or tb_clr) begin
    if (bus.clr === 1'b1 || tb_clr) latch_q = 1'b0;
    else if (pre)                   latch_q = 1'b1;
  end

  // A stuck latch holds FLAG high regardless of CLR.
  assign bus.flag = latch_q | stuck;

  task automatic tick();
    @(posedge i_c);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {7'd0, bus.busy}, 8'd0);
  endtask

  task automatic do_event();
    int n = 0;
    pre = 1'b1;
    tick();
    pre = 1'b0;
    bus.ack = 1'b1;
    while (bus.clr !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("wrap_clr", {7'd0, bus.clr}, 8'd1);
    bus.ack = 1'b0;
    wait_idle("wrap_idle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.ack = 1'b1;
    pre     = 1'b1;
    i_r     = 1'b1;

    // Reset with FLAG and ACK high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_req",  {7'd0, bus.req},  8'd0);
      chk("rst_clr",  {7'd0, bus.clr},  8'd0);
      chk("rst_busy", {7'd0, bus.busy}, 8'd0);
      chk("rst_cnt",  bus.evt_cnt,      8'd0);
    end
    bus.ack = 1'b0;
    pre     = 1'b0;
    tb_clr  = 1'b1;
    tick();
    i_r    = 1'b0;
    tb_clr = 1'b0;
    tick();

    // Clean event
    pre = 1'b1;
    tick();                                   // edge 0
    pre = 1'b0;
    tick(); tick();                           // edges 1,2
    chk("clean_busy_e2", {7'd0, bus.busy}, 8'd1);
    tick(); tick();                           // edges 3,4
    chk("clean_req_e4", {7'd0, bus.req}, 8'd0);
    tick();                                   // edge 5
    chk("clean_req_e5", {7'd0, bus.req}, 8'd1);
    tick(); tick();                           // edges 6,7
    chk("clean_req_e7", {7'd0, bus.req}, 8'd1);
    chk("clean_clr_e7", {7'd0, bus.clr}, 8'd0);
    bus.ack = 1'b1;
    tick();                                   // edge 8
    bus.ack = 1'b0;
    chk("clean_req_e8", {7'd0, bus.req}, 8'd0);
    chk("clean_clr_e8", {7'd0, bus.clr}, 8'd1);
    chk("clean_cnt_e8", bus.evt_cnt, 8'd1);
    chk("clean_flag_e8", {7'd0, bus.flag}, 8'd0);
    tick();                                   // edge 9
    chk("clean_clr_e9", {7'd0, bus.clr}, 8'd1);
    tick();                                   // edge 10
    chk("clean_clr_e10", {7'd0, bus.clr}, 8'd0);
    chk("clean_busy_e10", {7'd0, bus.busy}, 8'd1);
    tick();                                   // edge 11
    chk("clean_busy_e11", {7'd0, bus.busy}, 8'd0);

    // Glitch: FLAG high for 3 captures only
    pre = 1'b1;
    tick();                                   // edge 0
    pre = 1'b0;
    tick(); tick();                           // edges 1,2
    chk("glitch_busy_e2", {7'd0, bus.busy}, 8'd1);
    tb_clr = 1'b1;
    tick(); tick();                           // edges 3,4
    chk("glitch_busy_e4", {7'd0, bus.busy}, 8'd1);
    chk("glitch_req_e4",  {7'd0, bus.req},  8'd0);
    tick();                                   // edge 5
    chk("glitch_busy_e5", {7'd0, bus.busy}, 8'd0);
    chk("glitch_req_e5",  {7'd0, bus.req},  8'd0);
    chk("glitch_cnt",     bus.evt_cnt,      8'd1);
    tb_clr = 1'b0;
    tick();

    // Early level ACK
    bus.ack = 1'b1;
    pre = 1'b1;
    tick();                                   // edge 0
    pre = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    chk("early_req_e4", {7'd0, bus.req}, 8'd0);
    tick();                                   // edge 5
    chk("early_req_e5", {7'd0, bus.req}, 8'd1);
    chk("early_clr_e5", {7'd0, bus.clr}, 8'd0);
    tick();                                   // edge 6
    chk("early_req_e6", {7'd0, bus.req}, 8'd0);
    chk("early_clr_e6", {7'd0, bus.clr}, 8'd1);
    chk("early_cnt_e6", bus.evt_cnt, 8'd2);
    bus.ack = 1'b0;
    wait_idle("early_idle");
    chk("early_cnt_end", bus.evt_cnt, 8'd2);

    // Reset during PEND with FLAG still high
    pre = 1'b1;
    tick();                                   // edge 0
    pre = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    chk("midrst_req_e5", {7'd0, bus.req}, 8'd1);
    tick();                                   // edge 6
    i_r = 1'b1;
    tick();                                   // edge 7 (reset)
    i_r = 1'b0;
    chk("midrst_req",  {7'd0, bus.req},  8'd0);
    chk("midrst_busy", {7'd0, bus.busy}, 8'd0);
    chk("midrst_cnt",  bus.evt_cnt,      8'd0);
    for (int i = 8; i <= 12; i++) tick();
    chk("midrst_req_e12", {7'd0, bus.req}, 8'd0);
    tick();                                   // edge 13
    chk("midrst_req_e13", {7'd0, bus.req}, 8'd1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("midrst_clr", {7'd0, bus.clr}, 8'd1);
    chk("midrst_cnt_ack", bus.evt_cnt, 8'd1);
    wait_idle("midrst_idle");

    // Counter wrap
    i_r = 1'b1;
    tick();
    i_r = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) begin
      do_event();
      if (i == 254) chk("wrap_cnt_255", bus.evt_cnt, 8'd255);
    end
    chk("wrap_cnt_0", bus.evt_cnt, 8'd0);

    // Stuck-high FLAG holds WAITLOW
    stuck = 1'b1;
    n = 0;
    while (bus.req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("stuck_req", {7'd0, bus.req}, 8'd1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("stuck_clr", {7'd0, bus.clr}, 8'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("stuck_busy", {7'd0, bus.busy}, 8'd1);
    chk("stuck_req2", {7'd0, bus.req},  8'd0);
    chk("stuck_clr2", {7'd0, bus.clr},  8'd0);
    chk("stuck_cnt",  bus.evt_cnt,      8'd1);
    stuck = 1'b0;
    wait_idle("stuck_idle");
    chk("stuck_req_end", {7'd0, bus.req}, 8'd0);
    chk("stuck_cnt_end", bus.evt_cnt, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
